iter_xy_ctrl: RTL and testbench

- Sequences a 2D raster iteration (x inner, y outer) over fixed bounds; emits one (x,y) coordinate per accepted beat on a valid/ready stream.
- Sits between a frame-level start/done controller and pixel or address datapaths (framebuffer clear, display scan, test-pattern generators).
- Replaces ad-hoc nesting of single-axis fixed iterators with a single start/busy/done-controlled scheduler.

---
 rtl/iter_pkg.sv | 17 +
 rtl/iter_axis.sv | 30 +++
 rtl/iter_xy_ctrl.sv | 104 ++++++++++
 tb/tb_iter_xy_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iter_pkg.sv
// Shared types and helpers for the 2D raster iterator: state encoding and axis width.
package iter_pkg;

    typedef enum logic [1:0] {
        ITER_IDLE = 2'd0,
        ITER_RUN  = 2'd1,
        ITER_DONE = 2'd2
    } iter_state_t;

    // Counter width able to hold 0..max; never narrower than one bit.
    function automatic int iter_width(input int max);
        int w;
        w = $clog2(max + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/iter_axis.sv
// Single-axis counter 0..MAX_VALUE that wraps to 0 on inc at the top; clear beats inc.
module iter_axis
    import iter_pkg::*;
#(
    parameter int MAX_VALUE = 1,
    localparam int W = iter_width(MAX_VALUE)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] val,
    output logic         last
);

    localparam logic [W-1:0] MAX_V = W'(MAX_VALUE);

    assign last = (val == MAX_V);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            val <= '0;
        end else if (clear) begin
            val <= '0;
        end else if (inc) begin
            val <= last ? '0 : val + W'(1);
        end
    end

endmodule

// File: rtl/iter_xy_ctrl.sv
// Start/busy/done raster scheduler emitting (x,y) beats on a valid/ready stream, x inner.
// Define ITER_XY_CTRL_CONTINUOUS_EN to restart the raster back-to-back with no DONE bubble.
//
// state     | meaning
// ITER_IDLE | waiting for start, counters held at 0
// ITER_RUN  | coordinate presented, advances on each accepted beat
// ITER_DONE | one-cycle end-of-frame, done pulse
module iter_xy_ctrl
    import iter_pkg::*;
#(
    parameter int X_MAX = 639,
    parameter int Y_MAX = 479,
    localparam int X_WIDTH = iter_width(X_MAX),
    localparam int Y_WIDTH = iter_width(Y_MAX)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [X_WIDTH-1:0] x,
    output logic [Y_WIDTH-1:0] y,
    output logic               last_x,
    output logic               last,
    output logic               busy,
    output logic               done
);

    iter_state_t state, state_nxt;
    logic        beat;
    logic        x_at_max;
    logic        y_at_max;
    logic        clear_axes;
    logic        frame_end;
    logic        done_r;

    assign out_valid  = (state == ITER_RUN);
    assign busy       = (state == ITER_RUN);
    assign beat       = out_valid && out_ready;
    assign last_x     = out_valid && x_at_max;
    assign last       = last_x && y_at_max;
    assign frame_end  = beat && last && !abort;
    // Axes wrap on their own at the final beat; clear only covers abort and non-RUN states.
    assign clear_axes = (state != ITER_RUN) || abort;
    assign done       = done_r;

    iter_axis #(.MAX_VALUE(X_MAX)) u_axis_x (
        .clk   (clk),
        .reset (reset),
        .clear (clear_axes),
        .inc   (beat),
        .val   (x),
        .last  (x_at_max)
    );

    iter_axis #(.MAX_VALUE(Y_MAX)) u_axis_y (
        .clk   (clk),
        .reset (reset),
        .clear (clear_axes),
        .inc   (beat && x_at_max),
        .val   (y),
        .last  (y_at_max)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ITER_IDLE;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_r <= frame_end;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ITER_IDLE: begin
                if (start) begin
                    state_nxt = ITER_RUN;
                end
            end
            ITER_RUN: begin
                if (abort) begin
                    state_nxt = ITER_IDLE;
                end else if (frame_end) begin
`ifdef ITER_XY_CTRL_CONTINUOUS_EN
                    state_nxt = ITER_RUN;
`else
                    state_nxt = ITER_DONE;
`endif
                end
            end
            ITER_DONE: begin
                state_nxt = ITER_IDLE;
            end
            default: begin
                state_nxt = ITER_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_iter_xy_ctrl.sv
// Directed self-checking bench for iter_xy_ctrl: 4x3 raster instance plus a 1x1 degenerate instance.
module tb_iter_xy_ctrl;

    logic clk;
    logic reset;
    logic start_a, abort_a, ready_a;
    logic start_b, abort_b, ready_b;

    logic       va, lxa, la, ba, da;
    logic [1:0] xa;
    logic [1:0] ya;
    logic       vb, lxb, lb, bb, db;
    logic [0:0] xb;
    logic [0:0] yb;

    int n_cmp = 0;
    int n_err = 0;

    iter_xy_ctrl #(.X_MAX(3), .Y_MAX(2)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .start     (start_a),
        .abort     (abort_a),
        .out_ready (ready_a),
        .out_valid (va),
        .x         (xa),
        .y         (ya),
        .last_x    (lxa),
        .last      (la),
        .busy      (ba),
        .done      (da)
    );

    iter_xy_ctrl #(.X_MAX(0), .Y_MAX(0)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .start     (start_b),
        .abort     (abort_b),
        .out_ready (ready_b),
        .out_valid (vb),
        .x         (xb),
        .y         (yb),
        .last_x    (lxb),
        .last      (lb),
        .busy      (bb),
        .done      (db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        #3;
        n_cmp++;
        if (va !== 1'b0 || ba !== 1'b0 || da !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got valid=%b busy=%b done=%b want 0 0 0", va, ba, da);
        end
        n_cmp++;
        if (xa !== 2'd0 || ya !== 2'd0) begin
            n_err++;
            $display("FAIL reset_xy: got (%0d,%0d) want (0,0)", xa, ya);
        end
        n_cmp++;
        if (vb !== 1'b0 || db !== 1'b0) begin
            n_err++;
            $display("FAIL reset_b: got valid=%b done=%b want 0 0", vb, db);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int beats = 0, busy_cnt = 0, done_cnt = 0, done_at = -1, last_at = -1;
        logic exp_lx, exp_l;
        start_a = 1'b1;
        ready_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (ba) busy_cnt++;
            if (da) begin
                done_cnt++;
                done_at = c;
            end
            if (va) begin
                exp_lx = (beats % 4 == 3);
                exp_l  = (beats == 11);
                n_cmp++;
                if (xa !== 2'(beats % 4) || ya !== 2'(beats / 4)) begin
                    n_err++;
                    $display("FAIL basic_coord beat %0d: got (%0d,%0d) want (%0d,%0d)", beats, xa, ya, beats % 4, beats / 4);
                end
                n_cmp++;
                if (lxa !== exp_lx || la !== exp_l) begin
                    n_err++;
                    $display("FAIL basic_last beat %0d: got last_x=%b last=%b want %b %b", beats, lxa, la, exp_lx, exp_l);
                end
                beats++;
                last_at = c;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (beats != 12) begin
            n_err++;
            $display("FAIL basic_beats: got %0d want 12", beats);
        end
        n_cmp++;
        if (busy_cnt != 12) begin
            n_err++;
            $display("FAIL basic_busy: got %0d cycles want 12", busy_cnt);
        end
        n_cmp++;
        if (done_cnt != 1 || done_at != last_at + 1) begin
            n_err++;
            $display("FAIL basic_done: got %0d pulses at %0d want 1 at %0d", done_cnt, done_at, last_at + 1);
        end
    endtask

    task automatic test_stall();
        int beats = 0, stalls = 0;
        start_a = 1'b1;
        ready_a = 1'b0;
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 0; c < 200 && beats < 12; c++) begin
            n_cmp++;
            if (va !== 1'b1) begin
                n_err++;
                $display("FAIL stall_valid cycle %0d: got %b want 1", c, va);
            end else begin
                n_cmp++;
                if (xa !== 2'(beats % 4) || ya !== 2'(beats / 4)) begin
                    n_err++;
                    $display("FAIL stall_coord beat %0d: got (%0d,%0d) want (%0d,%0d)", beats, xa, ya, beats % 4, beats / 4);
                end
                if (ready_a) beats++;
                else stalls++;
            end
            @(negedge clk);
            ready_a = 1'($urandom_range(0, 1));
        end
        ready_a = 1'b1;
        n_cmp++;
        if (beats != 12 || stalls == 0) begin
            n_err++;
            $display("FAIL stall_beats: got %0d beats %0d stalls want 12 beats and >0 stalls", beats, stalls);
        end
        n_cmp++;
        if (da !== 1'b1 || va !== 1'b0) begin
            n_err++;
            $display("FAIL stall_done: got done=%b valid=%b want 1 0", da, va);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int beats = 0, done_cnt = 0;
        start_a = 1'b1;
        ready_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 0; c < 6; c++) begin
            n_cmp++;
            if (va !== 1'b1 || xa !== 2'(c % 4) || ya !== 2'(c / 4)) begin
                n_err++;
                $display("FAIL abort_pre beat %0d: got v=%b (%0d,%0d) want 1 (%0d,%0d)", c, va, xa, ya, c % 4, c / 4);
            end
            if (c < 5) @(negedge clk);
        end
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        n_cmp++;
        if (va !== 1'b0 || ba !== 1'b0 || da !== 1'b0 || xa !== 2'd0 || ya !== 2'd0) begin
            n_err++;
            $display("FAIL abort_idle: got v=%b busy=%b done=%b (%0d,%0d) want 0 0 0 (0,0)", va, ba, da, xa, ya);
        end
        @(negedge clk);
        n_cmp++;
        if (da !== 1'b0 || va !== 1'b0) begin
            n_err++;
            $display("FAIL abort_nodone: got done=%b valid=%b want 0 0", da, va);
        end
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (da) done_cnt++;
            if (va) begin
                n_cmp++;
                if (xa !== 2'(beats % 4) || ya !== 2'(beats / 4)) begin
                    n_err++;
                    $display("FAIL abort_replay beat %0d: got (%0d,%0d) want (%0d,%0d)", beats, xa, ya, beats % 4, beats / 4);
                end
                beats++;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (beats != 12 || done_cnt != 1) begin
            n_err++;
            $display("FAIL abort_replay_end: got %0d beats %0d done want 12 1", beats, done_cnt);
        end
    endtask

    task automatic test_async_reset();
        int beats = 0;
        bit seen_done = 0;
        start_a = 1'b1;
        ready_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (va !== 1'b0 || ba !== 1'b0 || da !== 1'b0) begin
            n_err++;
            $display("FAIL areset_flags: got v=%b busy=%b done=%b want 0 0 0", va, ba, da);
        end
        n_cmp++;
        if (xa !== 2'd0 || ya !== 2'd0) begin
            n_err++;
            $display("FAIL areset_xy: got (%0d,%0d) want (0,0)", xa, ya);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 0; c < 20 && !seen_done; c++) begin
            if (da) seen_done = 1;
            if (va) begin
                n_cmp++;
                if (xa !== 2'(beats % 4) || ya !== 2'(beats / 4)) begin
                    n_err++;
                    $display("FAIL areset_fresh beat %0d: got (%0d,%0d) want (%0d,%0d)", beats, xa, ya, beats % 4, beats / 4);
                end
                beats++;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!seen_done || beats != 12) begin
            n_err++;
            $display("FAIL areset_frame: got done_seen=%0d beats=%0d want 1 12", seen_done, beats);
        end
        @(negedge clk);
    endtask

    task automatic test_degenerate();
        logic exp_v, exp_d;
        start_b = 1'b1;
        ready_b = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 9; c++) begin
            exp_v = (c % 3 == 0);
            exp_d = (c % 3 == 1);
            n_cmp++;
            if (vb !== exp_v || db !== exp_d) begin
                n_err++;
                $display("FAIL degen_seq cycle %0d: got v=%b done=%b want %b %b", c, vb, db, exp_v, exp_d);
            end
            if (exp_v) begin
                n_cmp++;
                if (xb !== 1'b0 || yb !== 1'b0 || lb !== 1'b1 || lxb !== 1'b1) begin
                    n_err++;
                    $display("FAIL degen_beat cycle %0d: got (%0d,%0d) last=%b last_x=%b want (0,0) 1 1", c, xb, yb, lb, lxb);
                end
            end
            @(negedge clk);
        end
        start_b = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_continuous();
        logic exp_d;
        start_a = 1'b1;
        ready_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 0; c < 24; c++) begin
            exp_d = (c == 12);
            n_cmp++;
            if (va !== 1'b1 || xa !== 2'((c % 12) % 4) || ya !== 2'((c % 12) / 4)) begin
                n_err++;
                $display("FAIL cont_coord cycle %0d: got v=%b (%0d,%0d) want 1 (%0d,%0d)", c, va, xa, ya, (c % 12) % 4, (c % 12) / 4);
            end
            n_cmp++;
            if (da !== exp_d) begin
                n_err++;
                $display("FAIL cont_done cycle %0d: got %b want %b", c, da, exp_d);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (da !== 1'b1 || va !== 1'b1 || xa !== 2'd0 || ya !== 2'd0) begin
            n_err++;
            $display("FAIL cont_frame2_end: got done=%b v=%b (%0d,%0d) want 1 1 (0,0)", da, va, xa, ya);
        end
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        n_cmp++;
        if (va !== 1'b0 || ba !== 1'b0 || da !== 1'b0) begin
            n_err++;
            $display("FAIL cont_abort: got v=%b busy=%b done=%b want 0 0 0", va, ba, da);
        end
    endtask

    initial begin
        reset   = 1'b0;
        start_a = 1'b0;
        abort_a = 1'b0;
        ready_a = 1'b0;
        start_b = 1'b0;
        abort_b = 1'b0;
        ready_b = 1'b0;
        test_reset();
`ifdef ITER_XY_CTRL_CONTINUOUS_EN
        test_continuous();
`else
        test_basic();
        test_stall();
        test_abort();
        test_async_reset();
        test_degenerate();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
